// File: rtl/bcd_scan_driver_if.sv
// Bundle between a controller and the BCD scan driver: the conversion request
// (start/bin), conversion status, and the multiplexed digit/anode outputs.
interface bcd_scan_driver_if #(
    parameter int unsigned WIDTH = 14
);
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [3:0]       bcd;
    logic [3:0]       an;

    // Controller side: requests conversions and observes the display outputs.
    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  overflow,
        input  bcd,
        input  an
    );

    // Driver side.
    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output overflow,
        output bcd,
        output an
    );
endinterface

// File: rtl/bcd_scan_driver.sv
// Binary to packed-BCD converter (shift-add-3) feeding a four-digit display
// register, plus a free-running digit scanner with active-low anode enables.
// Code 4'hF blanks a digit (leading zeros, out-of-range values).
module bcd_scan_driver #(
    parameter int unsigned WIDTH    = 14,
    parameter int unsigned SCAN_DIV = 100000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    bcd_scan_driver_if.slave io_bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StUpdate
    } state_t;

    state_t           r_state;
    logic [15:0]      r_acc;
    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_req;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;
    logic [15:0]      r_disp;

    logic [PW-1:0]    r_presc;
    logic [1:0]       r_idx;
    logic [3:0]       r_bcd;
    logic [3:0]       r_an_pend;
    logic [3:0]       r_an;

    logic [14:0]      w_acc_adj;
    logic [15:0]      w_disp_next;
    logic [3:0]       w_digit;
    logic             w_bin_ovf;
    logic             w_tc;

    assign w_bin_ovf = {{(32 - WIDTH){1'b0}}, io_bus.bin} > 32'd9999;
    assign w_tc      = (r_presc == PW'(SCAN_DIV - 1));

    // Add-3 correction on each nibble >= 5 before the shift; only the low three
    // bits of the top nibble survive the shift, so only those are formed.
    always_comb begin
        w_acc_adj = '0;
        for (int i = 0; i < 3; i++) begin
            w_acc_adj[i*4 +: 4] = (r_acc[i*4 +: 4] >= 4'd5) ? r_acc[i*4 +: 4] + 4'd3
                                                             : r_acc[i*4 +: 4];
        end
        w_acc_adj[14:12] = r_acc[14:12] + ((r_acc[15:12] >= 4'd5) ? 3'd3 : 3'd0);
    end

    // Display image for the finished conversion, with overflow and leading-zero blanking.
    always_comb begin
        w_disp_next = r_acc;
        if (r_ovf_req) begin
            w_disp_next = 16'hFFFF;
        end else if (BLANK_LZ) begin
            if (r_acc[15:12] == 4'd0) begin
                w_disp_next[15:12] = 4'hF;
                if (r_acc[11:8] == 4'd0) begin
                    w_disp_next[11:8] = 4'hF;
                    if (r_acc[7:4] == 4'd0) begin
                        w_disp_next[7:4] = 4'hF;
                    end
                end
            end
        end
    end

    // Digit selected by the scan index.
    always_comb begin
        w_digit = r_disp[3:0];
        unique case (r_idx)
            2'd0: w_digit = r_disp[3:0];
            2'd1: w_digit = r_disp[7:4];
            2'd2: w_digit = r_disp[11:8];
            2'd3: w_digit = r_disp[15:12];
            default: w_digit = 4'hF;
        endcase
    end

    // Conversion FSM: accept, shift WIDTH times, then publish to the display register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_acc     <= '0;
            r_sr      <= '0;
            r_cnt     <= '0;
            r_ovf_req <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_disp    <= 16'hFFFF;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        r_sr      <= io_bus.bin;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_ovf_req <= w_bin_ovf;
                        r_busy    <= 1'b1;
                        r_state   <= StConvert;
                    end
                end
                StConvert: begin
                    r_acc <= {w_acc_adj, r_sr[WIDTH-1]};
                    r_sr  <= r_sr << 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= StUpdate;
                    end
                end
                StUpdate: begin
                    r_disp  <= w_disp_next;
                    r_ovf   <= r_ovf_req;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Scanner: bcd loads when the prescaler is at 0; the anode follows one cycle
    // later so it lines up with the decoder's registered segment output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc   <= '0;
            r_idx     <= 2'd0;
            r_bcd     <= 4'hF;
            r_an_pend <= 4'b1111;
            r_an      <= 4'b1111;
        end else begin
            if (w_tc) begin
                r_presc <= '0;
                r_idx   <= r_idx + 2'd1;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            if (r_presc == '0) begin
                r_bcd     <= w_digit;
                r_an_pend <= ~(4'b0001 << r_idx);
            end
            r_an <= r_an_pend;
        end
    end

    assign io_bus.busy     = r_busy;
    assign io_bus.done     = r_done;
    assign io_bus.overflow = r_ovf;
    assign io_bus.bcd      = r_bcd;
    assign io_bus.an       = r_an;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Bench for bcd_scan_driver: two instances (leading-zero blanking on/off) share
// the same request stream; expected results are queued per request and checked
// when done pulses, then the scanned digits are reassembled and compared.
module tb_bcd_scan_driver;

    localparam int unsigned WIDTH    = 14;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned NVEC     = 11;

    typedef struct {
        logic [WIDTH-1:0] bin;
        logic [15:0]      disp_lz;
        logic [15:0]      disp_nb;
        logic             ovf;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bcd_scan_driver_if #(.WIDTH(WIDTH)) bus_lz ();
    bcd_scan_driver_if #(.WIDTH(WIDTH)) bus_nb ();

    assign bus_nb.start = bus_lz.start;
    assign bus_nb.bin   = bus_lz.bin;

    bcd_scan_driver #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut_lz (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus_lz)
    );

    bcd_scan_driver #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut_nb (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus_nb)
    );

    vec_t vecs [NVEC];
    vec_t sb_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] put_digit(input logic [15:0] d, input logic [3:0] an,
                                              input logic [3:0] v);
        logic [15:0] r;
        r = d;
        case (an)
            4'b1110: r[3:0]   = v;
            4'b1101: r[7:4]   = v;
            4'b1011: r[11:8]  = v;
            4'b0111: r[15:12] = v;
            default: r        = 16'hEEEE;
        endcase
        return r;
    endfunction

    // Reassemble both displays from the scan outputs, sampling bcd whenever the anode moves.
    task automatic read_disp(output logic [15:0] d_lz, output logic [15:0] d_nb);
        logic [3:0] p_lz;
        logic [3:0] p_nb;
        d_lz = 16'hEEEE;
        d_nb = 16'hEEEE;
        repeat (SCAN_DIV + 2) @(negedge clk);
        p_lz = bus_lz.an;
        p_nb = bus_nb.an;
        repeat (4 * SCAN_DIV + 4) begin
            @(negedge clk);
            if (bus_lz.an != p_lz) d_lz = put_digit(d_lz, bus_lz.an, bus_lz.bcd);
            if (bus_nb.an != p_nb) d_nb = put_digit(d_nb, bus_nb.an, bus_nb.bcd);
            p_lz = bus_lz.an;
            p_nb = bus_nb.an;
        end
    endtask

    task automatic run_conv(input vec_t v);
        int          lat;
        int          busy_cyc;
        vec_t        e;
        logic [15:0] d_lz;
        logic [15:0] d_nb;
        sb_q.push_back(v);
        @(negedge clk);
        bus_lz.start = 1'b1;
        bus_lz.bin   = v.bin;
        @(negedge clk);
        bus_lz.start = 1'b0;
        lat      = -1;
        busy_cyc = 0;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            if (bus_lz.done) begin
                lat = k;
            end else begin
                if (bus_lz.busy) busy_cyc++;
                @(negedge clk);
            end
        end
        if (lat < 0) lat = 999;
        e = sb_q.pop_front();
        check($sformatf("latency bin=%0d", e.bin), lat, WIDTH + 1);
        check($sformatf("busy_cycles bin=%0d", e.bin), busy_cyc, WIDTH + 1);
        check($sformatf("busy_at_done bin=%0d", e.bin), bus_lz.busy, 1'b0);
        check($sformatf("ovf_lz bin=%0d", e.bin), bus_lz.overflow, e.ovf);
        check($sformatf("ovf_nb bin=%0d", e.bin), bus_nb.overflow, e.ovf);
        @(negedge clk);
        check($sformatf("done_width bin=%0d", e.bin), bus_lz.done, 1'b0);
        read_disp(d_lz, d_nb);
        check($sformatf("disp_lz bin=%0d", e.bin), d_lz, e.disp_lz);
        check($sformatf("disp_nb bin=%0d", e.bin), d_nb, e.disp_nb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [3:0]  prev_an;
        logic [3:0]  exp_an;
        int          cyc;
        int          n_done;
        int          last_done;
        int          gap;
        logic [15:0] d_lz;
        logic [15:0] d_nb;
        vec_t        e;

        vecs[0]  = '{bin: 14'd1234,  disp_lz: 16'h1234, disp_nb: 16'h1234, ovf: 1'b0};
        vecs[1]  = '{bin: 14'd7,     disp_lz: 16'hFFF7, disp_nb: 16'h0007, ovf: 1'b0};
        vecs[2]  = '{bin: 14'd0,     disp_lz: 16'hFFF0, disp_nb: 16'h0000, ovf: 1'b0};
        vecs[3]  = '{bin: 14'd9999,  disp_lz: 16'h9999, disp_nb: 16'h9999, ovf: 1'b0};
        vecs[4]  = '{bin: 14'd10000, disp_lz: 16'hFFFF, disp_nb: 16'hFFFF, ovf: 1'b1};
        vecs[5]  = '{bin: 14'd42,    disp_lz: 16'hFF42, disp_nb: 16'h0042, ovf: 1'b0};
        vecs[6]  = '{bin: 14'd100,   disp_lz: 16'hF100, disp_nb: 16'h0100, ovf: 1'b0};
        vecs[7]  = '{bin: 14'd16383, disp_lz: 16'hFFFF, disp_nb: 16'hFFFF, ovf: 1'b1};
        vecs[8]  = '{bin: 14'd905,   disp_lz: 16'hF905, disp_nb: 16'h0905, ovf: 1'b0};
        vecs[9]  = '{bin: 14'd1000,  disp_lz: 16'h1000, disp_nb: 16'h1000, ovf: 1'b0};
        vecs[10] = '{bin: 14'd5,     disp_lz: 16'hFFF5, disp_nb: 16'h0005, ovf: 1'b0};

        bus_lz.start = 1'b0;
        bus_lz.bin   = '0;

        // Reset state and first scan cycle.
        repeat (3) @(negedge clk);
        check("rst_bcd", bus_lz.bcd, 4'hF);
        check("rst_an", bus_lz.an, 4'b1111);
        check("rst_busy", bus_lz.busy, 1'b0);
        check("rst_done", bus_lz.done, 1'b0);
        check("rst_ovf", bus_lz.overflow, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("an_after_first_load", bus_lz.an, 4'b1111);
        check("bcd_after_first_load", bus_lz.bcd, 4'hF);
        @(negedge clk);
        check("an_first", bus_lz.an, 4'b1110);
        prev_an = bus_lz.an;
        exp_an  = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            exp_an = {exp_an[2:0], exp_an[3]};
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (bus_lz.an == prev_an && cyc < 3 * SCAN_DIV);
            check($sformatf("an_step%0d", i), bus_lz.an, exp_an);
            check($sformatf("an_period%0d", i), cyc, SCAN_DIV);
            prev_an = bus_lz.an;
        end

        // Table of single conversions.
        for (int i = 0; i < NVEC; i++) run_conv(vecs[i]);

        // start held high: back-to-back conversions.
        @(negedge clk);
        bus_lz.start = 1'b1;
        bus_lz.bin   = 14'd1234;
        n_done    = 0;
        last_done = -1;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (bus_lz.done) begin
                n_done++;
                if (last_done >= 0) begin
                    gap = k - last_done;
                    check("b2b_done_interval", gap, WIDTH + 2);
                end
                last_done = k;
            end
        end
        check("b2b_done_count_ge3", n_done >= 3, 1'b1);
        bus_lz.start = 1'b0;
        cyc = 0;
        while (bus_lz.busy && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);

        // A second start during CONVERT is ignored.
        e = '{bin: 14'd321, disp_lz: 16'hF321, disp_nb: 16'h0321, ovf: 1'b0};
        sb_q.push_back(e);
        bus_lz.start = 1'b1;
        bus_lz.bin   = 14'd321;
        @(negedge clk);
        bus_lz.start = 1'b0;
        repeat (4) @(negedge clk);
        bus_lz.start = 1'b1;
        bus_lz.bin   = 14'd9999;
        @(negedge clk);
        bus_lz.start = 1'b0;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus_lz.done) n_done++;
        end
        e = sb_q.pop_front();
        check("ignored_start_done_count", n_done, 1);
        check("ignored_start_ovf", bus_lz.overflow, e.ovf);
        read_disp(d_lz, d_nb);
        check("ignored_start_disp_lz", d_lz, e.disp_lz);
        check("ignored_start_disp_nb", d_nb, e.disp_nb);

        // Reset mid-conversion aborts and blanks.
        @(negedge clk);
        bus_lz.start = 1'b1;
        bus_lz.bin   = 14'd1234;
        @(negedge clk);
        bus_lz.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", bus_lz.busy, 1'b0);
        check("midrst_bcd", bus_lz.bcd, 4'hF);
        check("midrst_an", bus_lz.an, 4'b1111);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus_lz.done) n_done++;
        end
        check("midrst_no_done", n_done, 0);
        read_disp(d_lz, d_nb);
        check("midrst_disp_lz", d_lz, 16'hFFFF);
        check("midrst_disp_nb", d_nb, 16'hFFFF);
        run_conv(vecs[5]);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
